seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 18 +
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Segment bit order, blank glyph and BCD-to-7-segment encoding.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment masks, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_A     = 7'b000_0001;
    localparam logic [6:0] SEG_B     = 7'b000_0010;
    localparam logic [6:0] SEG_C     = 7'b000_0100;
    localparam logic [6:0] SEG_D     = 7'b000_1000;
    localparam logic [6:0] SEG_E     = 7'b001_0000;
    localparam logic [6:0] SEG_F     = 7'b010_0000;
    localparam logic [6:0] SEG_G     = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'd1:    s = SEG_B | SEG_C;
            4'd2:    s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'd3:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'd4:    s = SEG_B | SEG_C | SEG_F | SEG_G;
            4'd5:    s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'd6:    s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd7:    s = SEG_A | SEG_B | SEG_C;
            4'd8:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd9:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational single-digit decoder, active-high, with blank input.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_bcd);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Multiplexed 7-segment driver with LZ blanking, blink and
//            frame-synchronous display loading.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 0,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_SCAN_W  = (SCAN_DIV > 2)     ? $clog2(SCAN_DIV)     : 1;
    localparam int c_IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int c_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_FRAMES - 1);
    localparam logic                 c_INV        = (ACTIVE_LOW != 0);

    logic [c_SCAN_W-1:0]     r_scan_cnt;
    logic [c_IDX_W-1:0]      r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic [c_BLINK_W-1:0]    r_blink_cnt;
    blink_phase_e            r_blink_phase;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_cur;
    logic                    w_lz_cur;
    logic                    w_blank;
    logic [6:0]              w_seg;

    assign w_slot_end = (r_scan_cnt == c_SCAN_LAST);
    assign w_boundary = w_slot_end && (r_digit_idx == c_IDX_LAST);

    // A digit is a leading zero when it and everything above it is zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_sel[gi] = (r_digit_idx == c_IDX_W'(gi));
            if ((gi == 0) || (LZ_BLANK == 0)) begin : g_no_lz
                assign w_lz[gi] = 1'b0;
            end else begin : g_lz
                assign w_lz[gi] = (r_active[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        w_cur    = 4'd0;
        w_lz_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_cur    = w_cur | r_active[4*i +: 4];
                w_lz_cur = w_lz_cur | w_lz[i];
            end
        end
    end

    // Gating by blink_en directly lets a deassert show segments on the next cycle
    assign w_blank = w_lz_cur || (blink_en && (r_blink_phase == BLINK_OFF));

    bcd_to_seg7 u_dec (
        .i_bcd   (w_cur),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt    <= '0;
            r_digit_idx   <= '0;
            r_shadow      <= '0;
            r_active      <= '0;
            r_pending     <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= BLINK_ON;
            r_seg         <= SEG_BLANK ^ {7{c_INV}};
            r_an          <= {NUM_DIGITS{c_INV}};
            r_frame_done  <= 1'b0;
        end else begin
            r_scan_cnt <= w_slot_end ? '0 : r_scan_cnt + 1'b1;
            if (w_slot_end) begin
                r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? '0 : r_digit_idx + 1'b1;
            end

            // Active data only changes on a frame boundary, so no frame tears
            if (w_boundary) begin
                if (load) begin
                    r_active  <= digits_in;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (load) begin
                r_shadow  <= digits_in;
                r_pending <= 1'b1;
            end

            if (!blink_en) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= BLINK_ON;
            end else if (w_boundary) begin
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= (r_blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            r_seg        <= w_seg ^ {7{c_INV}};
            r_an         <= w_sel ^ {NUM_DIGITS{c_INV}};
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench: active-high and active-low instances
//            compared every cycle against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND    = 3;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;
    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blink_en = 1'b0;
    logic [11:0] digits_in = 12'h000;
    logic [6:0]  seg_hi, seg_lo;
    logic [2:0]  an_hi, an_lo;
    logic        fd_hi, fd_lo;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_pos = 0;
    logic [11:0] m_active = '0, m_shadow = '0;
    logic        m_pending = 1'b0;
    int          m_bframes = 0;
    logic [6:0]  m_seg = '0;
    logic [2:0]  m_an = '0;
    logic        m_fd = 1'b0;
    bit          started = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0), .LZ_BLANK(1)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blink_en(blink_en),
        .seg(seg_hi), .an(an_hi), .frame_done(fd_hi)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blink_en(blink_en),
        .seg(seg_lo), .an(an_lo), .frame_done(fd_lo)
    );

    function automatic logic [6:0] expect_seg(input logic [11:0] v, input int d);
        logic [11:0] upper;
        int          code;
        upper = v >> (4 * d);
        code  = int'(upper & 12'hF);
        if (d > 0 && upper == 12'd0) return 7'h00;
        if (code > 9) return 7'h00;
        return GLYPH[code];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame decides the digit; data swaps at frame end
    task automatic model_step();
        int d;
        bit bnd;
        if (rst) begin
            m_pos = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_bframes = 0;
            m_seg = 7'h00; m_an = 3'b000; m_fd = 1'b0;
        end else begin
            d     = m_pos / SD;
            bnd   = (m_pos == FRAME - 1);
            m_an  = 3'(1 << d);
            m_fd  = bnd;
            if (blink_en && ((m_bframes / BF) % 2 == 1)) m_seg = 7'h00;
            else                                         m_seg = expect_seg(m_active, d);
            if (bnd) begin
                if (load) begin
                    m_active = digits_in; m_pending = 1'b0;
                end else if (m_pending) begin
                    m_active = m_shadow; m_pending = 1'b0;
                end
            end else if (load) begin
                m_shadow = digits_in; m_pending = 1'b1;
            end
            if (!blink_en) m_bframes = 0;
            else if (bnd)  m_bframes++;
            m_pos = bnd ? 0 : m_pos + 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("cycle_hi", {21'd0, fd_hi, an_hi, seg_hi}, {21'd0, m_fd, m_an, m_seg});
            chk("cycle_lo", {21'd0, fd_lo, an_lo, seg_lo}, {21'd0, m_fd, ~m_an, ~m_seg});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (fd_hi) return;
        end
        checks++; errors++;
        $display("FAIL wait_fd: no frame_done within %0d cycles", 4 * FRAME);
    endtask

    task automatic wait_last_pos();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_pos == FRAME - 1) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL wait_last_pos: boundary cycle not reached");
    endtask

    task automatic pulse_load(input logic [11:0] v);
        digits_in = v;
        load      = 1'b1;
        tick(1);
        load      = 1'b0;
    endtask

    // Checks the first cycle of each slot of the frame after the next frame_done
    task automatic pin_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2);
        logic [6:0] s [3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        wait_fd();
        for (int k = 0; k < ND; k++) begin
            if (k == 0) tick(1);
            else        tick(SD);
            chk({name, "_hi"}, {22'd0, an_hi, seg_hi}, {22'd0, 3'(1 << k), s[k]});
            chk({name, "_lo"}, {22'd0, an_lo, seg_lo}, {22'd0, ~3'(1 << k), ~s[k]});
        end
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        for (int i = 0; i < ND; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int n;
        tick(3);
        chk("reset_hi", {20'd0, fd_hi, an_hi, seg_hi}, {20'd0, 1'b0, 3'b000, 7'h00});
        chk("reset_lo", {20'd0, fd_lo, an_lo, seg_lo}, {20'd0, 1'b0, 3'b111, 7'h7F});
        rst = 1'b0;
        tick(1);
        chk("first_hi", {20'd0, an_hi, seg_hi}, {20'd0, 3'b001, 7'h3F});
        chk("first_lo", {20'd0, an_lo, seg_lo}, {20'd0, 3'b110, 7'h40});

        tick(4);
        pulse_load(12'h145);
        tick(1);
        chk("no_tear", {25'd0, seg_hi}, {25'd0, 7'h00});
        pin_frame("v145", 7'h6D, 7'h66, 7'h06);

        wait_fd();
        n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick(1);
            n++;
            if (fd_hi) break;
        end
        chk("fd_period", n, FRAME);

        pulse_load(12'h005);
        pin_frame("v005", 7'h6D, 7'h00, 7'h00);
        pulse_load(12'h040);
        pin_frame("v040", 7'h3F, 7'h66, 7'h00);
        pulse_load(12'hBCF);
        pin_frame("vBCF", 7'h00, 7'h00, 7'h00);

        pulse_load(12'h111);
        pulse_load(12'h222);
        wait_last_pos();
        pulse_load(12'h333);
        pin_frame("v333", 7'h4F, 7'h4F, 7'h4F);
        pin_frame("v333b", 7'h4F, 7'h4F, 7'h4F);

        pulse_load(12'h145);
        pin_frame("b_on", 7'h6D, 7'h66, 7'h06);
        blink_en = 1'b1;
        wait_fd();
        pin_frame("b_off", 7'h00, 7'h00, 7'h00);
        blink_en = 1'b0;
        tick(1);
        chk("blink_drop", {22'd0, an_hi, seg_hi}, {22'd0, 3'b100, 7'h06});

        pulse_load(12'h777);
        rst = 1'b1;
        tick(1);
        chk("midrst_hi", {22'd0, an_hi, seg_hi}, {22'd0, 3'b000, 7'h00});
        chk("midrst_lo", {22'd0, an_lo, seg_lo}, {22'd0, 3'b111, 7'h7F});
        rst = 1'b0;
        pin_frame("post_rst", 7'h3F, 7'h00, 7'h00);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0 || (m_pos == FRAME - 1 && $urandom_range(0, 1) == 0)) begin
                digits_in = rand_bcd();
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 79) == 0) blink_en = ~blink_en;
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        load = 1'b0; rst = 1'b0; blink_en = 1'b0;
        tick(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
